// File: rtl/mas_pkg.sv
// Shared definitions for the MAS sequencer: sequencer states and default widths.
package mas_pkg;

    localparam int W_D_DEF   = 5;
    localparam int W_O_DEF   = 4;
    localparam int CNT_W_DEF = 8;
    localparam int SEL_W     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STG1 = 2'd1,
        STG2 = 2'd2
    } state_e;

endpackage

// File: rtl/mas_out_slot.sv
// Single-entry valid/ready output holding register with a wrapping handshake counter.
module mas_out_slot
    import mas_pkg::*;
#(
    parameter int W_D   = W_D_DEF,
    parameter int W_O   = W_O_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [W_D-1:0]   tdout_i,
    input  logic [SEL_W-1:0] tcmp_i,
    input  logic [W_O-1:0]   dout_i,
    input  logic             ready_i,
    output logic             free_o,
    output logic             valid_o,
    output logic [W_D-1:0]   tdout_o,
    output logic [SEL_W-1:0] tcmp_o,
    output logic [W_O-1:0]   dout_o,
    output logic [CNT_W-1:0] done_cnt_o
);

    logic             valid_q, valid_d;
    logic [W_D-1:0]   tdout_q, tdout_d;
    logic [SEL_W-1:0] tcmp_q, tcmp_d;
    logic [W_O-1:0]   dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign free_o = !valid_q || ready_i;

    // A load in the same cycle as a handshake wins, so valid stays high with new data.
    always_comb begin
        valid_d = valid_q;
        tdout_d = tdout_q;
        tcmp_d  = tcmp_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
            cnt_d   = cnt_q + 1'b1;
        end
        if (load_i) begin
            valid_d = 1'b1;
            tdout_d = tdout_i;
            tcmp_d  = tcmp_i;
            dout_d  = dout_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            tdout_q <= '0;
            tcmp_q  <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tdout_q <= tdout_d;
            tcmp_q  <= tcmp_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
        end
    end

    assign valid_o    = valid_q;
    assign tdout_o    = tdout_q;
    assign tcmp_o     = tcmp_q;
    assign dout_o     = dout_q;
    assign done_cnt_o = cnt_q;

endmodule

// File: rtl/mas_seq_ctrl.sv
// Two-stage MAS sequencer sharing one external ALU and one Q comparator between stages.
module mas_seq_ctrl
    import mas_pkg::*;
#(
    parameter int W_D   = W_D_DEF,
    parameter int W_O   = W_O_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W_D-1:0]   in_din1,
    input  logic [W_D-1:0]   in_din2,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [W_D-1:0]   in_q,
    output logic [SEL_W-1:0] alu_sel,
    output logic [W_D-1:0]   alu_din1,
    output logic [W_D-1:0]   alu_din2,
    input  logic [W_D-1:0]   alu_dout,
    output logic [W_D-1:0]   cmp_din,
    output logic [W_D-1:0]   cmp_q,
    input  logic [SEL_W-1:0] cmp_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_D-1:0]   out_tdout,
    output logic [SEL_W-1:0] out_tcmp,
    output logic [W_O-1:0]   out_dout,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    state_e           state_q, state_d;
    logic [W_D-1:0]   d1_q, d1_d, d2_q, d2_d, q_q, q_d, tdout_q, tdout_d;
    logic [SEL_W-1:0] sel_q, sel_d, tcmp_q, tcmp_d;
    logic             slot_free, load;

    // ALU drives depend only on registered state, keeping the external ALU loop-free.
    always_comb begin
        alu_sel  = '0;
        alu_din1 = '0;
        alu_din2 = '0;
        case (state_q)
            STG1: begin
                alu_sel  = sel_q;
                alu_din1 = d1_q;
                alu_din2 = d2_q;
            end
            STG2: begin
                alu_sel  = tcmp_q;
                alu_din1 = tdout_q;
                alu_din2 = q_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        cmp_din = '0;
        cmp_q   = '0;
        case (state_q)
            STG1: begin
                cmp_din = alu_dout;
                cmp_q   = q_q;
            end
            STG2: begin
                cmp_din = tdout_q;
                cmp_q   = q_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        d1_d     = d1_q;
        d2_d     = d2_q;
        sel_d    = sel_q;
        q_d      = q_q;
        tdout_d  = tdout_q;
        tcmp_d   = tcmp_q;
        in_ready = 1'b0;
        load     = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = slot_free;
                if (in_valid && slot_free) begin
                    d1_d    = in_din1;
                    d2_d    = in_din2;
                    sel_d   = in_sel;
                    q_d     = in_q;
                    state_d = STG1;
                end
            end
            STG1: begin
                tdout_d = alu_dout;
                tcmp_d  = cmp_sel;
                state_d = STG2;
            end
            STG2: begin
                if (slot_free) begin
                    load    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d1_q    <= '0;
            d2_q    <= '0;
            sel_q   <= '0;
            q_q     <= '0;
            tdout_q <= '0;
            tcmp_q  <= '0;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            sel_q   <= sel_d;
            q_q     <= q_d;
            tdout_q <= tdout_d;
            tcmp_q  <= tcmp_d;
        end
    end

    mas_out_slot #(
        .W_D   (W_D),
        .W_O   (W_O),
        .CNT_W (CNT_W)
    ) u_out_slot (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .tdout_i    (tdout_q),
        .tcmp_i     (tcmp_q),
        .dout_i     (alu_dout[W_O-1:0]),
        .ready_i    (out_ready),
        .free_o     (slot_free),
        .valid_o    (out_valid),
        .tdout_o    (out_tdout),
        .tcmp_o     (out_tcmp),
        .dout_o     (out_dout),
        .done_cnt_o (done_cnt)
    );

    assign busy = (state_q != IDLE) || out_valid;

endmodule

// File: tb/tb_mas_seq_ctrl.sv
// Bench for mas_seq_ctrl: stub ALU/comparator, transaction-level reference model, directed and random traffic.
module tb_mas_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready;
    logic [4:0] in_din1, in_din2, in_q;
    logic [1:0] in_sel;
    logic [1:0] alu_sel;
    logic [4:0] alu_din1, alu_din2, alu_dout;
    logic [4:0] cmp_din, cmp_q;
    logic [1:0] cmp_sel;
    logic       out_valid, out_ready;
    logic [4:0] out_tdout;
    logic [1:0] out_tcmp;
    logic [3:0] out_dout;
    logic       busy;
    logic [7:0] done_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mas_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_din1   (in_din1),
        .in_din2   (in_din2),
        .in_sel    (in_sel),
        .in_q      (in_q),
        .alu_sel   (alu_sel),
        .alu_din1  (alu_din1),
        .alu_din2  (alu_din2),
        .alu_dout  (alu_dout),
        .cmp_din   (cmp_din),
        .cmp_q     (cmp_q),
        .cmp_sel   (cmp_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tdout (out_tdout),
        .out_tcmp  (out_tcmp),
        .out_dout  (out_dout),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    // Stub ALU: 00 add, 01 sub, 10 add, 11 xor. Stub comparator: 01 greater, 10 less, 00 equal.
    function automatic logic [4:0] aluFn(input logic [1:0] s, input logic [4:0] a, input logic [4:0] b);
        case (s)
            2'b01:   return a - b;
            2'b11:   return a ^ b;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [1:0] cmpFn(input logic [4:0] d, input logic [4:0] q);
        if ($signed(d) > $signed(q)) return 2'b01;
        if ($signed(d) < $signed(q)) return 2'b10;
        return 2'b00;
    endfunction

    assign alu_dout = aluFn(alu_sel, alu_din1, alu_din2);
    assign cmp_sel  = cmpFn(cmp_din, cmp_q);

    typedef struct {
        logic [4:0] d1, d2, q, tdout;
        logic [1:0] sel, tcmp;
        logic [3:0] dout;
    } res_t;

    // Reference model: one bundle in flight at most, one result slot, handshake counter.
    bit         mInflight;
    int         mAge;
    res_t       mFl;
    bit         mOutValid;
    res_t       mOut;
    logic [7:0] mDone;
    bit         dutAccepted;

    function automatic res_t evalBundle(input logic [4:0] a, input logic [4:0] b,
                                        input logic [1:0] s, input logic [4:0] q);
        res_t       r;
        logic [4:0] full;
        r.d1    = a;
        r.d2    = b;
        r.sel   = s;
        r.q     = q;
        r.tdout = aluFn(s, a, b);
        r.tcmp  = cmpFn(r.tdout, q);
        full    = aluFn(r.tcmp, r.tdout, q);
        r.dout  = full[3:0];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mInflight = 1'b0;
        mAge      = 0;
        mOutValid = 1'b0;
        mDone     = '0;
    endtask

    // One clock cycle: drive at posedge+1, compare at negedge, advance the model at posedge.
    task automatic applyStimulus(input bit v, input logic [4:0] a, input logic [4:0] b,
                                 input logic [1:0] s, input logic [4:0] q, input bit rdy);
        bit         expReady, hs, load, acc;
        logic [1:0] eSel;
        logic [4:0] eD1, eD2, eCd, eCq;
        in_valid  = v;
        in_din1   = a;
        in_din2   = b;
        in_sel    = s;
        in_q      = q;
        out_ready = rdy;
        @(negedge clk);
        expReady = !mInflight && (!mOutValid || rdy);
        eSel = '0; eD1 = '0; eD2 = '0; eCd = '0; eCq = '0;
        if (mInflight && mAge == 0) begin
            eSel = mFl.sel; eD1 = mFl.d1; eD2 = mFl.d2; eCd = mFl.tdout; eCq = mFl.q;
        end else if (mInflight) begin
            eSel = mFl.tcmp; eD1 = mFl.tdout; eD2 = mFl.q; eCd = mFl.tdout; eCq = mFl.q;
        end
        checkOutput("in_ready",  32'(in_ready),  32'(expReady));
        checkOutput("out_valid", 32'(out_valid), 32'(mOutValid));
        checkOutput("busy",      32'(busy),      32'(mInflight || mOutValid));
        checkOutput("done_cnt",  32'(done_cnt),  32'(mDone));
        checkOutput("alu_sel",   32'(alu_sel),   32'(eSel));
        checkOutput("alu_din1",  32'(alu_din1),  32'(eD1));
        checkOutput("alu_din2",  32'(alu_din2),  32'(eD2));
        checkOutput("cmp_din",   32'(cmp_din),   32'(eCd));
        checkOutput("cmp_q",     32'(cmp_q),     32'(eCq));
        if (mOutValid) begin
            checkOutput("out_tdout", 32'(out_tdout), 32'(mOut.tdout));
            checkOutput("out_tcmp",  32'(out_tcmp),  32'(mOut.tcmp));
            checkOutput("out_dout",  32'(out_dout),  32'(mOut.dout));
        end
        dutAccepted = v && in_ready;
        @(posedge clk);
        hs   = mOutValid && rdy;
        load = mInflight && mAge >= 1 && (!mOutValid || rdy);
        acc  = v && expReady;
        if (hs) mDone = mDone + 8'd1;
        if (load) begin
            mOutValid = 1'b1;
            mOut      = mFl;
            mInflight = 1'b0;
        end else if (hs) begin
            mOutValid = 1'b0;
        end
        if (mInflight) mAge++;
        if (acc) begin
            mInflight = 1'b1;
            mAge      = 0;
            mFl       = evalBundle(a, b, s, q);
        end
        #1;
    endtask

    task automatic idleCycle(input bit rdy);
        applyStimulus(1'b0, 5'd0, 5'd0, 2'd0, 5'd0, rdy);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({tag, "_out_tdout"}, 32'(out_tdout), 32'd0);
        checkOutput({tag, "_out_tcmp"},  32'(out_tcmp),  32'd0);
        checkOutput({tag, "_out_dout"},  32'(out_dout),  32'd0);
        checkOutput({tag, "_done_cnt"},  32'(done_cnt),  32'd0);
        checkOutput({tag, "_busy"},      32'(busy),      32'd0);
        checkOutput({tag, "_alu_sel"},   32'(alu_sel),   32'd0);
        checkOutput({tag, "_alu_din1"},  32'(alu_din1),  32'd0);
        checkOutput({tag, "_cmp_q"},     32'(cmp_q),     32'd0);
    endtask

    // Called at posedge+1; asserts reset between edges and releases it on a falling edge.
    task automatic applyReset();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 checkAllZero("reset");
        modelReset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int dutAcc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_din1   = '0;
        in_din2   = '0;
        in_sel    = '0;
        in_q      = '0;
        out_ready = 1'b0;
        modelReset();
        #1 checkAllZero("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic: 3+2=5 in stage 1, 5>4 gives 01, stage 2 computes 5-4=1.
        applyStimulus(1'b1, 5'd3, 5'd2, 2'b00, 5'd4, 1'b1);
        checkOutput("basic_s1_alu_din1", 32'(alu_din1), 32'd3);
        checkOutput("basic_s1_cmp_din",  32'(cmp_din),  32'd5);
        idleCycle(1'b1);
        checkOutput("basic_s2_alu_sel",  32'(alu_sel),  32'd1);
        checkOutput("basic_s2_alu_din1", 32'(alu_din1), 32'd5);
        checkOutput("basic_s2_alu_din2", 32'(alu_din2), 32'd4);
        idleCycle(1'b1);
        checkOutput("basic_valid", 32'(out_valid), 32'd1);
        checkOutput("basic_tdout", 32'(out_tdout), 32'd5);
        checkOutput("basic_tcmp",  32'(out_tcmp),  32'd1);
        checkOutput("basic_dout",  32'(out_dout),  32'd1);
        idleCycle(1'b1);
        checkOutput("basic_done_cnt", 32'(done_cnt), 32'd1);

        // Backpressure: result 2 held while a new bundle waits; handshake and accept coincide.
        applyStimulus(1'b1, 5'd1, 5'd1, 2'b00, 5'd0, 1'b0);
        idleCycle(1'b0);
        idleCycle(1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 5'd4, 5'd1, 2'b00, 5'd30, 1'b0);
        checkOutput("bp_hold_valid", 32'(out_valid), 32'd1);
        checkOutput("bp_hold_dout",  32'(out_dout),  32'd2);
        checkOutput("bp_in_ready",   32'(in_ready),  32'd0);
        applyStimulus(1'b1, 5'd4, 5'd1, 2'b00, 5'd30, 1'b1);
        checkOutput("bp_done_cnt", 32'(done_cnt), 32'd2);
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("bp_second_dout", 32'(out_dout), 32'd7);
        idleCycle(1'b1);

        // Truncation: -3+-3=-6, less than -4 gives 10, stage 2 -6+-4=-10=5'b10110.
        applyStimulus(1'b1, 5'd29, 5'd29, 2'b00, 5'd28, 1'b1);
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("trunc_dout",  32'(out_dout),  32'h6);
        checkOutput("trunc_tdout", 32'(out_tdout), 32'h1A);
        checkOutput("trunc_tcmp",  32'(out_tcmp),  32'd2);
        idleCycle(1'b1);

        // Reset during stage 1; the aborted bundle must never appear.
        applyStimulus(1'b1, 5'd3, 5'd3, 2'b01, 5'd2, 1'b1);
        applyReset();
        for (int i = 0; i < 4; i++) idleCycle(1'b1);
        applyStimulus(1'b1, 5'd6, 5'd1, 2'b00, 5'd2, 1'b1);
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("postrst_dout", 32'(out_dout), 32'd5);
        idleCycle(1'b1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom),
                          2'($urandom), 5'($urandom), ($urandom_range(0, 9) < 7));
        end

        // Wrap: 256 back-to-back bundles at one per three cycles.
        applyReset();
        dutAcc = 0;
        for (int i = 0; i < 766; i++) begin
            applyStimulus(1'b1, 5'($urandom), 5'($urandom), 2'($urandom), 5'($urandom), 1'b1);
            if (dutAccepted) dutAcc++;
        end
        checkOutput("wrap_accepts", 32'(dutAcc), 32'd256);
        for (int i = 0; i < 3; i++) idleCycle(1'b1);
        checkOutput("wrap_done_cnt", 32'(done_cnt), 32'd0);
        checkOutput("wrap_idle",     32'(busy),     32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
